// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and execution-unit FSM states.
// Also used by the ALU controller.
package alu_pkg;

  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_XOR = 4'b1001,
    OP_SLT = 4'b1100,
    OP_NE  = 4'b1110
  } alu_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One combinational shift step of up to 2**AMT_W-1 bits.
// Left shifts and logical right shifts zero-fill; arithmetic right shifts sign-fill.
module alu_shift_step #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AMT_W      = 3
) (
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  dir,
  input  logic                  arith,
  input  logic [AMT_W-1:0]      amount,
  output logic [DATA_WIDTH-1:0] shifted
);

  // Separate branches keep the signed operand self-contained so >>> stays arithmetic
  always_comb begin
    shifted = value;
    if (dir) begin
      shifted = value << amount;
    end else if (arith) begin
      shifted = $signed(value) >>> amount;
    end else begin
      shifted = value >> amount;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith ops, multi-cycle iterative shifts,
// valid/ready result handshake with flush support.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  localparam int unsigned AMT_W = $clog2(SHIFT_STEP + 1);

  alu_state_e            state_q, state_d;
  alu_op_e               op;
  logic [DATA_WIDTH-1:0] val_q, val_d, res_d, alu_res, step_out;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d, shamt;
  logic [AMT_W-1:0]      step_amt;
  logic                  left_q, left_d, arith_q, arith_d;
  logic                  valid_d, zero_d, accept;

  assign op       = alu_op_e'(Operation);
  assign shamt    = SrcB[SHAMT_W-1:0];
  assign in_ready = (state_q == IDLE) && (!out_valid || out_ready) && !flush && !reset;
  assign accept   = in_valid && in_ready;
  assign step_amt = (32'(cnt_q) > SHIFT_STEP) ? AMT_W'(SHIFT_STEP) : AMT_W'(cnt_q);

  alu_shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .AMT_W      (AMT_W)
  ) u_shift_step (
    .value   (val_q),
    .dir     (left_q),
    .arith   (arith_q),
    .amount  (step_amt),
    .shifted (step_out)
  );

  // Single-cycle datapath; shifts only reach here with a zero shift amount
  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:                 alu_res = SrcA & SrcB;
      OP_OR:                  alu_res = SrcA | SrcB;
      OP_XOR:                 alu_res = SrcA ^ SrcB;
      OP_ADD:                 alu_res = SrcA + SrcB;
      OP_SUB:                 alu_res = SrcA - SrcB;
      OP_SLL, OP_SRL, OP_SRA: alu_res = SrcA;
      OP_SLT:                 alu_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
      OP_EQ:                  alu_res = DATA_WIDTH'(SrcA == SrcB);
      OP_NE:                  alu_res = DATA_WIDTH'(SrcA != SrcB);
      default:                alu_res = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    valid_d = out_valid;
    res_d   = ALUResult;
    zero_d  = Zero;
    val_d   = val_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    arith_d = arith_q;

    if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end

    if (state_q == IDLE) begin
      if (accept) begin
        if (is_shift_op(op) && (shamt != '0)) begin
          state_d = SHIFT;
          val_d   = SrcA;
          cnt_d   = shamt;
          left_d  = (op == OP_SLL);
          arith_d = (op == OP_SRA);
        end else begin
          valid_d = 1'b1;
          res_d   = alu_res;
          zero_d  = (alu_res == '0);
        end
      end
    end else begin
      val_d = step_out;
      cnt_d = cnt_q - SHAMT_W'(step_amt);
      if (cnt_d == '0) begin
        state_d = IDLE;
        valid_d = 1'b1;
        res_d   = step_out;
        zero_d  = (step_out == '0);
      end
    end

    // Hazard kill drops any pending result or in-flight shift
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      val_q     <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      arith_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      ALUResult <= res_d;
      Zero      <= zero_d;
      val_q     <= val_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      arith_q   <= arith_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  localparam int unsigned DW   = 32;
  localparam int unsigned STEP = 4;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready, Zero;
  logic [3:0]    Operation;
  logic [DW-1:0] SrcA, SrcB, ALUResult;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(
    .DATA_WIDTH (DW),
    .SHIFT_STEP (STEP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  function automatic logic [DW-1:0] ref_result(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    int unsigned        sh;
    logic signed [DW-1:0] sa;
    sh = int'(b[4:0]);
    sa = a;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b1001: return a ^ b;
      4'b0100: return a << sh;
      4'b0101: return a >> sh;
      4'b0111: return sa >>> sh;
      4'b1100: return ($signed(a) < $signed(b)) ? DW'(1) : '0;
      4'b1000: return (a == b) ? DW'(1) : '0;
      4'b1110: return (a != b) ? DW'(1) : '0;
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [DW-1:0] b);
    int sh;
    sh = int'(b[4:0]);
    if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && sh != 0)
      return 1 + (sh + int'(STEP) - 1) / int'(STEP);
    return 1;
  endfunction

  // Offer one op at a negedge; lat = cycles after the handshake until out_valid (-1 on timeout/refusal)
  task automatic run_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output int lat, output logic [DW-1:0] res, output logic z);
    @(negedge clk);
    lat = -1;
    res = '0;
    z   = 1'b0;
    if (in_ready !== 1'b1) return;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (out_valid === 1'b1) begin
        lat = k;
        res = ALUResult;
        z   = Zero;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Operation = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || ALUResult !== '0 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h zero=%b, want 0 0 0 0",
               in_ready, out_valid, ALUResult, Zero);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_sub();
    int lat; logic [DW-1:0] res; logic z;
    run_op(4'b0110, 32'd5, 32'd7, lat, res, z);
    checks++;
    if (lat !== 1 || res !== 32'hFFFF_FFFE || z !== 1'b0) begin
      errors++;
      $display("FAIL sub: lat=%0d res=%h zero=%b, want 1 fffffffe 0", lat, res, z);
    end
  endtask

  task automatic test_illegal();
    int lat; logic [DW-1:0] res; logic z;
    run_op(4'b0011, 32'd9, 32'd9, lat, res, z);
    checks++;
    if (lat !== 1 || res !== '0 || z !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op: lat=%0d res=%h zero=%b, want 1 0 1", lat, res, z);
    end
  endtask

  task automatic test_sra_latency();
    @(negedge clk);
    Operation = 4'b0111; SrcA = 32'h8000_0000; SrcB = 32'd31; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL sra_offer_ready: in_ready=%b want 1", in_ready);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sra_busy_N+%0d: in_ready=%b out_valid=%b, want 0 0", k, in_ready, out_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'hFFFF_FFFF || Zero !== 1'b0) begin
      errors++;
      $display("FAIL sra_result_N+9: out_valid=%b res=%h zero=%b, want 1 ffffffff 0",
               out_valid, ALUResult, Zero);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    Operation = 4'b1000; SrcA = 32'd3; SrcB = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || ALUResult !== 32'd1 || Zero !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold%0d: v=%b res=%h zero=%b in_ready=%b, want 1 1 0 0",
                 k, out_valid, ALUResult, Zero, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release_ready: in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    int seen;
    // Flush in the middle of a 5-step SLL
    @(negedge clk);
    Operation = 4'b0100; SrcA = 32'd1; SrcB = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_low: in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_N+3: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_no_result: out_valid seen %0d cycles, want 0", seen);
    end
    // Flush with in_valid accepts nothing
    @(negedge clk);
    Operation = 4'b0001; SrcA = 32'h55; SrcB = 32'hAA; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_accept: out_valid=%b want 0", out_valid);
    end
    // Flush drops a result held under backpressure
    out_ready = 1'b0;
    Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_held_result: out_valid=%b want 0", out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    @(negedge clk);
    Operation = 4'b0101; SrcA = 32'hF0; SrcB = 32'd16; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || ALUResult !== '0 || Zero !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: v=%b res=%h zero=%b in_ready=%b, want 0 0 0 0",
               out_valid, ALUResult, Zero, in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_shift_ready: in_ready=%b want 1", in_ready);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_shift_no_result: out_valid seen %0d cycles, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]    ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1001, 4'b1100};
    logic [DW-1:0] exp [8];
    logic [3:0]    op;
    logic [DW-1:0] a, b;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || ALUResult !== exp[i-1]) begin
          errors++;
          $display("FAIL back_to_back%0d: v=%b res=%h, want 1 %h", i - 1, out_valid, ALUResult, exp[i-1]);
        end
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back_ready%0d: in_ready=%b want 1", i, in_ready);
      end
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      b  = $urandom;
      exp[i] = ref_result(op, a, b);
      Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== exp[7]) begin
      errors++;
      $display("FAIL back_to_back7: v=%b res=%h, want 1 %h", out_valid, ALUResult, exp[7]);
    end
  endtask

  task automatic test_random();
    logic [3:0]    codes [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1001, 4'b0100,
                                  4'b0101, 4'b0111, 4'b1100, 4'b1000, 4'b1110};
    logic [3:0]    op;
    logic [DW-1:0] a, b, exp, res;
    logic          z;
    int            lat, exp_lat;
    out_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 10)];
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      exp     = ref_result(op, a, b);
      exp_lat = ref_latency(op, b);
      run_op(op, a, b, lat, res, z);
      checks++;
      if (lat != exp_lat || res !== exp || z !== (exp == '0)) begin
        errors++;
        $display("FAIL random%0d op=%b a=%h b=%h: lat=%0d res=%h zero=%b, want %0d %h %b",
                 i, op, a, b, lat, res, z, exp_lat, exp, (exp == '0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_illegal();
    test_sra_latency();
    test_backpressure();
    test_flush();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter SHIFT_STEP, default 4, max shift bits per cycle; power of 2, 1..DATA_WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  hazard-unit kill of in-flight/pending op.
REQ-006 SHALL have port in_valid  input  1  operation offered.
REQ-007 SHALL have port in_ready  output  1  unit can accept this cycle.
REQ-008 SHALL have port Operation  input  4  op code from ALU controller.
REQ-009 SHALL have ports SrcA, SrcB  input  DATA_WIDTH  operands.
REQ-010 SHALL have port out_valid  output  1  result held valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have ports ALUResult  output  DATA_WIDTH  and Zero  output  1  (ALUResult == 0).

Function
REQ-013 SHALL decode Operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1001 XOR, 0100 SLL, 0101 SRL, 0111 SRA, 1100 SLT (signed, result 1/0), 1000 EQ (A==B ->1), 1110 NE (A!=B ->1); any other code -> result 0.
REQ-014 SHALL accept an op on a cycle with in_valid && in_ready (handshake cycle N).
REQ-015 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-016 SHALL, for non-shift ops and shifts with SrcB[4:0]==0, register ALUResult/Zero and assert out_valid at N+1.
REQ-017 SHALL, for SLL/SRL/SRA with shamt=SrcB[4:0]>0, latch SrcA and shamt, enter SHIFT, shift by min(SHIFT_STEP, remaining) per cycle; out_valid asserts 1+ceil(shamt/SHIFT_STEP) cycles after N.
REQ-018 SHALL sign-fill for SRA and zero-fill for SRL/SLL at every step.
REQ-019 SHALL implement FSM IDLE->SHIFT on accepted shift with shamt>0; SHIFT->IDLE with result registered when remaining reaches 0; SHIFT->IDLE without result on flush.
REQ-020 SHALL hold ALUResult, Zero, out_valid stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on out_ready when no new result is produced that cycle; back-to-back single-cycle ops sustain one result per cycle.
REQ-022 SHALL, on flush, clear out_valid and return to IDLE next cycle; flush with in_valid accepts nothing.
REQ-023 SHALL perform ADD/SUB modulo 2^DATA_WIDTH, no overflow output.
REQ-024 SHALL ignore SrcB[DATA_WIDTH-1:5] for shifts.

Reset
REQ-025 SHALL on reset set state IDLE, out_valid 0, ALUResult 0, Zero 0, shift counter 0.
REQ-026 SHALL give reset priority over flush and handshakes, including mid-SHIFT.
REQ-027 SHALL hold in_ready 0 during the reset cycle.

Structure
REQ-028 SHALL place alu_op_e (Operation encodings) and alu_state_e (IDLE, SHIFT) in package alu_pkg, shared with the ALU controller.
REQ-029 SHALL use one sub-module alu_shift_step: combinational single step (value, dir, arith, amount<=SHIFT_STEP) -> shifted value.

Verification
REQ-030 SUB: A=5, B=7, Operation=0110 -> out_valid at N+1, ALUResult=0xFFFFFFFE, Zero=0.
REQ-031 SRA: A=0x80000000, B=31, SHIFT_STEP=4 -> out_valid at N+9, ALUResult=0xFFFFFFFF, in_ready=0 during N+1..N+8.
REQ-032 Backpressure: EQ A=B=3, out_ready=0 three cycles -> ALUResult=1 held, in_ready=0; out_ready=1 -> in_ready=1 same cycle.
REQ-033 Flush mid-shift: SLL A=1, B=20, flush at N+2 -> no out_valid, IDLE at N+3, in_ready=1.
REQ-034 Reset mid-shift: SRL A=0xF0, B=16, reset at N+1 -> next cycle out_valid=0, ALUResult=0, in_ready=1 after reset drops.
REQ-035 Illegal code 0011 with A=9, B=9 -> ALUResult=0, Zero=1 at N+1.
